// File: rtl/mem_bus_pkg.sv
// Shared types and default parameters for the instruction/data memory bus arbiter.
package mem_bus_pkg;

  localparam int DEF_TIMEOUT_CYCLES = 16;
  localparam int DEF_STARVE_LIMIT   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Data normally wins; fetch wins when it is alone or has waited out its starvation budget.
  function automatic owner_t pick_owner(input logic req_i, input logic req_d,
                                        input logic starve_hit);
    if (req_i && (!req_d || starve_hit)) begin
      return OWN_I;
    end
    return OWN_D;
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Counts BUSY cycles of the current bus transaction and flags the last allowed cycle.
module bus_watchdog
  import mem_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] r_cnt;

  // Cycle counter: cleared when a transaction starts, advanced each BUSY cycle, parked at LAST.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Expiry is raised during the final permitted BUSY cycle so the abort lands on its closing edge.
  assign expired = enable & (r_cnt == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port (fetch/data) arbiter onto a single memory bus, with starvation guard and timeout.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int STARVE_LIMIT   = DEF_STARVE_LIMIT
) (
  input  logic        clk,
  input  logic        reset,
  // fetch port
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  output logic        i_err,
  // data port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wmask,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_err,
  output logic        d_stall,
  // memory side
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wmask,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,
  input  logic        m_err
);

  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  state_t        r_state;
  logic [SW-1:0] r_starve_cnt;
  logic          r_m_req;
  logic          r_m_we;
  logic [31:0]   r_m_addr;
  logic [31:0]   r_m_wdata;
  logic [3:0]    r_m_wmask;
  logic [31:0]   r_i_rdata;
  logic [31:0]   r_d_rdata;
  logic          r_i_ack;
  logic          r_i_err;
  logic          r_d_ack;
  logic          r_d_err;

  logic          w_any_req;
  logic          w_starve_hit;
  owner_t        w_grant_owner;
  logic          w_busy;
  logic          w_grant;
  logic          w_done;
  logic          w_resp_ok;
  logic          w_resp_err;
  logic          w_wd_expired;

  assign w_any_req     = i_req | d_req;
  assign w_starve_hit  = (r_starve_cnt == STARVE_MAX);
  assign w_grant_owner = pick_owner(i_req, d_req, w_starve_hit);
  assign w_busy        = (r_state != IDLE);
  assign w_grant       = (r_state == IDLE) & w_any_req;
  assign w_done        = m_ack | m_err | w_wd_expired;
  // m_err dominates a simultaneous m_ack; a timeout (neither seen) also reports an error.
  assign w_resp_ok     = m_ack & ~m_err;
  assign w_resp_err    = ~w_resp_ok;

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_grant),
    .enable (w_busy),
    .expired(w_wd_expired)
  );

  // Arbitration FSM: grants from IDLE, holds the bus while BUSY, registers the owner's response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_m_req      <= 1'b0;
      r_m_we       <= 1'b0;
      r_m_addr     <= '0;
      r_m_wdata    <= '0;
      r_m_wmask    <= '0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
      r_i_ack      <= 1'b0;
      r_i_err      <= 1'b0;
      r_d_ack      <= 1'b0;
      r_d_err      <= 1'b0;
    end else begin
      r_i_ack <= 1'b0;
      r_i_err <= 1'b0;
      r_d_ack <= 1'b0;
      r_d_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_m_req <= 1'b1;
            if (w_grant_owner == OWN_D) begin
              r_state      <= BUSY_D;
              r_m_we       <= d_we;
              r_m_addr     <= d_addr;
              r_m_wdata    <= d_wdata;
              r_m_wmask    <= d_wmask;
              r_starve_cnt <= i_req ? (r_starve_cnt + 1'b1) : '0;
            end else begin
              r_state      <= BUSY_I;
              r_m_we       <= 1'b0;
              r_m_addr     <= i_addr;
              r_m_wdata    <= '0;
              r_m_wmask    <= '0;
              r_starve_cnt <= '0;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (w_done) begin
            r_state   <= IDLE;
            r_m_req   <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_wmask <= '0;
            // A requester that withdrew mid-transaction gets no response at all.
            if (r_state == BUSY_I) begin
              if (i_req) begin
                r_i_ack <= w_resp_ok;
                r_i_err <= w_resp_err;
                if (w_resp_ok) r_i_rdata <= m_rdata;
              end
            end else begin
              if (d_req) begin
                r_d_ack <= w_resp_ok;
                r_d_err <= w_resp_err;
                if (w_resp_ok) r_d_rdata <= m_rdata;
              end
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_m_req   <= 1'b0;
          r_m_we    <= 1'b0;
          r_m_wmask <= '0;
        end
      endcase
    end
  end

  assign m_req   = r_m_req;
  assign m_we    = r_m_we;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;
  assign m_wmask = r_m_wmask;
  assign i_rdata = r_i_rdata;
  assign i_ack   = r_i_ack;
  assign i_err   = r_i_err;
  assign d_rdata = r_d_rdata;
  assign d_ack   = r_d_ack;
  assign d_err   = r_d_err;
  assign d_stall = d_req & ~r_d_ack & ~r_d_err;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed, table-driven bench for mem_bus_arbiter.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wmask;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_err;
  logic        d_stall;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wmask;
  logic [31:0] m_rdata;
  logic        m_ack;
  logic        m_err;

  int n_checks = 0;
  int n_errors = 0;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(16), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err), .d_stall(d_stall),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask),
    .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          ack_at;
    logic        use_err;
    logic [31:0] rdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int busy;
    i_req   = ~v.is_d;
    i_addr  = v.addr;
    d_req   = v.is_d;
    d_we    = v.we;
    d_addr  = v.addr;
    d_wdata = v.wdata;
    d_wmask = v.wmask;
    m_ack   = 1'b0;
    m_err   = 1'b0;
    step();
    busy = 1;
    chk1("txn m_req first", m_req, 1'b1);
    chk("txn m_addr", m_addr, v.addr);
    chk1("txn m_we", m_we, v.is_d ? v.we : 1'b0);
    chk("txn m_wmask", {28'h0, m_wmask}, v.is_d ? {28'h0, v.wmask} : 32'h0);
    if (v.is_d) begin
      chk("txn m_wdata", m_wdata, v.wdata);
      chk1("txn d_stall busy", d_stall, 1'b1);
    end
    while (busy < v.ack_at) begin
      step();
      busy++;
      chk1("txn m_req hold", m_req, 1'b1);
      chk1("txn m_we hold", m_we, v.is_d ? v.we : 1'b0);
    end
    m_rdata = v.rdata;
    m_ack   = ~v.use_err;
    m_err   = v.use_err;
    step();
    m_ack = 1'b0;
    m_err = 1'b0;
    chk1("txn m_req done", m_req, 1'b0);
    chk1("txn m_we idle", m_we, 1'b0);
    if (v.is_d) begin
      chk1("txn d_ack", d_ack, ~v.use_err);
      chk1("txn d_err", d_err, v.use_err);
      chk("txn d_rdata", d_rdata, v.exp_rdata);
      chk1("txn d_stall resp", d_stall, 1'b0);
      chk("txn i silent", {30'h0, i_ack, i_err}, 32'h0);
    end else begin
      chk1("txn i_ack", i_ack, ~v.use_err);
      chk1("txn i_err", i_err, v.use_err);
      chk("txn i_rdata", i_rdata, v.exp_rdata);
      chk("txn d silent", {30'h0, d_ack, d_err}, 32'h0);
    end
    i_req = 1'b0;
    d_req = 1'b0;
    step();
    chk("txn pulse one cycle", {28'h0, i_ack, i_err, d_ack, d_err}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global time limit: got timeout expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    int busy;
    logic        exp_is_d[6];
    logic [31:0] exp_addr;

    //                 is_d we  addr          wdata         wmask ack err rdata         exp_rdata
    vecs[0] = '{1'b0, 1'b1, 32'h0000_0100, 32'h0,        4'hF, 2, 1'b0, 32'h0000_0013, 32'h0000_0013};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_2000, 32'hDEADBEEF, 4'hF, 1, 1'b0, 32'h0BAD_0001, 32'h0BAD_0001};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_3004, 32'h0,        4'h0, 3, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_3008, 32'h1,        4'h1, 1, 1'b1, 32'h9999_9999, 32'hCAFE_F00D};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,        4'h0, 2, 1'b1, 32'h7777_7777, 32'h0000_0013};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_4000, 32'h12345678, 4'h5, 4, 1'b0, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
    exp_is_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wmask = '0;
    m_rdata = '0; m_ack = 1'b0; m_err = 1'b0;
    step();
    step();
    chk("rst m_ctrl", {29'h0, m_req, m_we, |m_wmask}, 32'h0);
    chk("rst m_addr", m_addr, 32'h0);
    chk("rst m_wdata", m_wdata, 32'h0);
    chk("rst resp", {28'h0, i_ack, i_err, d_ack, d_err}, 32'h0);
    chk("rst i_rdata", i_rdata, 32'h0);
    chk("rst d_rdata", d_rdata, 32'h0);
    d_req = 1'b1;
    #1;
    chk1("rst d_stall comb", d_stall, 1'b1);
    d_req = 1'b0;
    #1;
    chk1("rst d_stall low", d_stall, 1'b0);
    reset = 1'b0;
    step();
    chk1("idle m_req", m_req, 1'b0);

    for (int k = 0; k < 6; k++) run_txn(vecs[k]);

    // Simultaneous fetch and store: data first, then fetch after one idle cycle.
    i_req = 1'b1; i_addr = 32'h0000_0100;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_2000; d_wdata = 32'hDEADBEEF; d_wmask = 4'hF;
    step();
    chk("sim first addr", m_addr, 32'h0000_2000);
    chk1("sim first we", m_we, 1'b1);
    chk1("sim d_stall", d_stall, 1'b1);
    m_rdata = 32'h0; m_ack = 1'b1;
    step();
    m_ack = 1'b0;
    chk1("sim d_ack", d_ack, 1'b1);
    chk1("sim i_ack quiet", i_ack, 1'b0);
    chk1("sim gap m_req", m_req, 1'b0);
    d_req = 1'b0;
    step();
    chk1("sim fetch m_req", m_req, 1'b1);
    chk("sim fetch addr", m_addr, 32'h0000_0100);
    chk1("sim fetch we", m_we, 1'b0);
    m_rdata = 32'h0000_0017; m_ack = 1'b1;
    step();
    m_ack = 1'b0;
    chk1("sim i_ack", i_ack, 1'b1);
    chk("sim i_rdata", i_rdata, 32'h0000_0017);
    i_req = 1'b0;

    // Starvation: both ports requesting continuously -> D D D D I D.
    i_req = 1'b1; i_addr = 32'h0000_0200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_5000; d_wmask = 4'h0;
    for (int g = 0; g < 6; g++) begin
      step();
      exp_addr = exp_is_d[g] ? 32'h0000_5000 : 32'h0000_0200;
      chk("starve grant addr", m_addr, exp_addr);
      m_rdata = 32'h1111_0000 + 32'(g); m_ack = 1'b1;
      step();
      m_ack = 1'b0;
      chk1("starve i_ack", i_ack, ~exp_is_d[g]);
      chk1("starve d_ack", d_ack, exp_is_d[g]);
    end
    chk("starve i_rdata", i_rdata, 32'h1111_0004);
    chk("starve d_rdata", d_rdata, 32'h1111_0005);
    i_req = 1'b0;
    d_req = 1'b0;
    step();

    // Timeout: load at 0x3000 never answered.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_3000;
    step();
    busy = 0;
    while (m_req && busy < 40) begin
      busy++;
      step();
    end
    chk("tmo busy cycles", 32'(busy), 32'd16);
    chk1("tmo d_err", d_err, 1'b1);
    chk1("tmo d_ack", d_ack, 1'b0);
    chk("tmo d_rdata", d_rdata, 32'h1111_0005);
    d_req = 1'b0;
    step();
    chk1("tmo d_err pulse", d_err, 1'b0);

    // m_ack and m_err together on a fetch.
    i_req = 1'b1; i_addr = 32'h0000_0400;
    step();
    m_rdata = 32'hFFFF_FFFF; m_ack = 1'b1; m_err = 1'b1;
    step();
    m_ack = 1'b0; m_err = 1'b0;
    chk1("both i_err", i_err, 1'b1);
    chk1("both i_ack", i_ack, 1'b0);
    chk("both i_rdata", i_rdata, 32'h1111_0004);
    i_req = 1'b0;
    step();

    // Requester withdraws mid-transaction: bus completes, no response.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_6000; d_wdata = 32'h5555_AAAA; d_wmask = 4'hF;
    step();
    d_req = 1'b0;
    step();
    chk1("wd m_req still", m_req, 1'b1);
    m_rdata = 32'h4242_4242; m_ack = 1'b1;
    step();
    m_ack = 1'b0;
    chk1("wd m_req done", m_req, 1'b0);
    chk("wd no resp", {30'h0, d_ack, d_err}, 32'h0);
    chk("wd d_rdata", d_rdata, 32'h1111_0005);
    step();

    // Reset pulsed mid-transaction.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_7000;
    step();
    chk1("rmid m_req before", m_req, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk1("rmid m_req async", m_req, 1'b0);
    d_req = 1'b0;
    m_ack = 1'b1;
    step();
    m_ack = 1'b0;
    chk("rmid no resp", {28'h0, i_ack, i_err, d_ack, d_err}, 32'h0);
    chk("rmid d_rdata", d_rdata, 32'h0);
    reset = 1'b0;
    step();
    chk1("rmid idle", m_req, 1'b0);
    run_txn(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
